// File: rtl/br_pkg.sv
// rtl/br_pkg.sv - shared types and default sizing for the register bank
package br_pkg;

    typedef enum logic {
        BR_IDLE  = 1'b0,
        BR_CLEAR = 1'b1
    } br_state_t;

    localparam int BR_WIDTH = 32;
    localparam int BR_DEPTH = 32;

endpackage

// File: rtl/br_sync_if.sv
// rtl/br_sync_if.sv - read/write/clear bus of the register bank
interface br_sync_if
    import br_pkg::*;
#(
    parameter int WIDTH = BR_WIDTH,
    parameter int AW    = $clog2(BR_DEPTH)
);
    logic [AW-1:0]    RR1;
    logic [AW-1:0]    RR2;
    logic [AW-1:0]    WriteReg;
    logic [WIDTH-1:0] WriteData;
    logic             RegWrite;
    logic             ClearReq;
    logic [WIDTH-1:0] RD1;
    logic [WIDTH-1:0] RD2;
    logic             Busy;

    modport master (
        output RR1, RR2, WriteReg, WriteData, RegWrite, ClearReq,
        input  RD1, RD2, Busy
    );

    modport slave (
        input  RR1, RR2, WriteReg, WriteData, RegWrite, ClearReq,
        output RD1, RD2, Busy
    );
endinterface

// File: rtl/br_clear_fsm.sv
// rtl/br_clear_fsm.sv - sequences a one-register-per-cycle bulk clear
module br_clear_fsm
    import br_pkg::*;
#(
    parameter int DEPTH = BR_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          clear_req,
    output logic          busy,
    output logic          clr_en,
    output logic [AW-1:0] clr_addr
);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    br_state_t     state_q;
    logic [AW-1:0] cnt_q;
    logic          busy_q;

    // A request seen while clearing is deliberately dropped, so the sweep never restarts.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= BR_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                BR_IDLE: begin
                    if (clear_req) begin
                        state_q <= BR_CLEAR;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                BR_CLEAR: begin
                    if (cnt_q == LAST) begin
                        state_q <= BR_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= BR_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign clr_en   = busy_q;
    assign clr_addr = cnt_q;
endmodule

// File: rtl/br_sync.sv
// rtl/br_sync.sv - 2R/1W register bank with write bypass, zero register and bulk clear
module br_sync
    import br_pkg::*;
#(
    parameter int WIDTH    = BR_WIDTH,
    parameter int DEPTH    = BR_DEPTH,
    parameter int AW       = $clog2(DEPTH),
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic     Clk,
    input  logic     Reset,
    br_sync_if.slave bus
);
    localparam bit ZR = (ZERO_REG != 0);
    localparam bit BP = (BYPASS != 0);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic          busy;
    logic          clr_en;
    logic [AW-1:0] clr_addr;
    logic          wr_in, rr1_in, rr2_in;
    logic          we;
    logic [WIDTH-1:0] rd1, rd2;

    br_clear_fsm #(.DEPTH(DEPTH), .AW(AW)) u_clear (
        .Clk       (Clk),
        .Reset     (Reset),
        .clear_req (bus.ClearReq),
        .busy      (busy),
        .clr_en    (clr_en),
        .clr_addr  (clr_addr)
    );

    // Only a non-power-of-two depth leaves address codes without a backing register.
    generate
        if (DEPTH == (1 << AW)) begin : g_full
            assign wr_in  = 1'b1;
            assign rr1_in = 1'b1;
            assign rr2_in = 1'b1;
        end else begin : g_part
            assign wr_in  = (bus.WriteReg < AW'(DEPTH));
            assign rr1_in = (bus.RR1 < AW'(DEPTH));
            assign rr2_in = (bus.RR2 < AW'(DEPTH));
        end
    endgenerate

    assign we = bus.RegWrite && !busy && wr_in && !(ZR && (bus.WriteReg == '0));

    always_comb begin
        mem_d = mem_q;
        if (clr_en) begin
            mem_d[clr_addr] = '0;
        end else if (we) begin
            mem_d[bus.WriteReg] = bus.WriteData;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        rd1 = '0;
        if (!rr1_in || (ZR && (bus.RR1 == '0))) begin
            rd1 = '0;
        end else if (BP && we && (bus.WriteReg == bus.RR1)) begin
            rd1 = bus.WriteData;
        end else begin
            rd1 = mem_q[bus.RR1];
        end
    end

    always_comb begin
        rd2 = '0;
        if (!rr2_in || (ZR && (bus.RR2 == '0))) begin
            rd2 = '0;
        end else if (BP && we && (bus.WriteReg == bus.RR2)) begin
            rd2 = bus.WriteData;
        end else begin
            rd2 = mem_q[bus.RR2];
        end
    end

    assign bus.RD1  = rd1;
    assign bus.RD2  = rd2;
    assign bus.Busy = busy;
endmodule
